cla4_adder_reg: RTL and testbench
=================================

// Module: cla4_adder_reg
// PURPOSE
//   4-bit carry-look-ahead adder with registered outputs. Operands arrive as
//   individual bit ports (a0..a3, b0..b3); the result leaves as s0..s3 plus c_out.
//   Carry-in is tied to 0 internally; every carry is computed in parallel from
//   generate/propagate terms, never rippled. Used as a small arithmetic leaf.
// PARAMETERS
//   none (width fixed at 4 bits; carry-in fixed at 0)
// PORTS
//   clk        in   1  system clock; all state updates on rising edge
//   rst        in   1  synchronous reset, active-high
//   in_valid   in   1  operand bits are valid this cycle
//   a0..a3     in   1 each  operand A; a0 = LSB, a3 = MSB
//   b0..b3     in   1 each  operand B; b0 = LSB, b3 = MSB
//   s0..s3     out  1 each  registered sum; s0 = LSB, s3 = MSB
//   c_out      out  1  registered carry-out (sum bit 4)
//   out_valid  out  1  s0..s3/c_out hold the result of a valid operand pair
// BEHAVIOUR
//   - One clock domain. Reset is synchronous and active-high: on a rising clk edge
//     with rst=1, s0..s3, c_out and out_valid all become 0. rst has priority over
//     in_valid.
//   - Combinational core, with i = 0..3:
//     g_i = a_i & b_i; p_i = a_i ^ b_i; c0 = 0
//     c1 = g0
//     c2 = g1 | p1&g0
//     c3 = g2 | p2&g1 | p2&p1&g0
//     c4 = g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0
//     sum_i = p_i ^ c_i; c_out = c4. No carry term may depend on another carry.
//   - {c_out,s3,s2,s1,s0} == {a3..a0} + {b3..b0}, unsigned 5-bit result.
//     The maximum sum is 15+15 = 30 (5'b11110). There is no overflow flag;
//     c_out serves as the overflow indication.
//   - Latency is exactly 1 cycle. On an edge with rst=0 and in_valid=1, the
//     outputs load the sum of the current operands and out_valid becomes 1.
//   - On an edge with rst=0 and in_valid=0, out_valid becomes 0 and
//     s0..s3/c_out keep their previous values.
//   - No backpressure: a new valid pair may be presented every cycle and gives
//     one result per cycle. Back-to-back operands each produce their own result
//     one cycle later.
//   - Reset asserted mid-stream: the next edge clears all outputs. The first
//     valid pair after rst falls appears one cycle later.
// TESTING
//   1. rst=1 for 2 cycles with random operands -> s=0000, c_out=0, out_valid=0.
//   2. A=0000, B=0000, in_valid=1 -> next cycle s=0000, c_out=0, out_valid=1.
//   3. A=0101 (5), B=0011 (3) -> s=1000, c_out=0. A=1111, B=0001 -> s=0000, c_out=1.
//   4. A=1111, B=1111 -> s=1110, c_out=1. A=1010, B=0101 -> s=1111, c_out=0.
//   5. Exhaustive sweep of all 256 A/B pairs back-to-back with in_valid=1 ->
//      each result equals A+B one cycle later, out_valid=1 throughout.
//   6. in_valid dropped for 1 cycle, then rst pulsed mid-sweep -> during the gap
//      out_valid=0 with outputs held; after reset outputs=0; the stream resumes
//      correctly one cycle after rst falls.

Source files
------------

// File: rtl/cla4_adder_reg.sv
// 4-bit carry-look-ahead adder with a one-cycle registered result.
// Every carry is a flat sum-of-products of generate/propagate terms, never rippled.
module cla4_adder_reg (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic a0,
    input  logic a1,
    input  logic a2,
    input  logic a3,
    input  logic b0,
    input  logic b1,
    input  logic b2,
    input  logic b3,
    output logic s0,
    output logic s1,
    output logic s2,
    output logic s3,
    output logic c_out,
    output logic out_valid
);

    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    logic [3:0] sum;

    assign a = {a3, a2, a1, a0};
    assign b = {b3, b2, b1, b0};

    assign g = a & b;
    assign p = a ^ b;

    // Carry-in is tied low, so c[0] contributes no terms to the higher carries.
    assign c[0] = 1'b0;
    assign c[1] = g[0];
    assign c[2] = g[1] | (p[1] & g[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);

    assign sum = p ^ c[3:0];

    // Handshake: no backpressure; a result appears with out_valid one edge
    // after in_valid, and the data registers hold while in_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0        <= 1'b0;
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            c_out     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                s0    <= sum[0];
                s1    <= sum[1];
                s2    <= sum[2];
                s3    <= sum[3];
                c_out <= c[4];
            end
        end
    end

endmodule

// File: tb/tb_cla4_adder_reg.sv
// Directed bench for cla4_adder_reg: reset, hand-computed vectors,
// exhaustive back-to-back sweep, and an in_valid gap followed by reset.
module tb_cla4_adder_reg;

    logic clk;
    logic rst;
    logic in_valid;
    logic a0, a1, a2, a3;
    logic b0, b1, b2, b3;
    logic s0, s1, s2, s3;
    logic c_out;
    logic out_valid;

    logic [4:0] res;
    int pass_count;
    int check_count;

    assign res = {c_out, s3, s2, s1, s0};

    cla4_adder_reg dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .b0(b0), .b1(b1), .b2(b2), .b3(b3),
        .s0(s0), .s1(s1), .s2(s2), .s3(s3),
        .c_out(c_out),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic v);
        {a3, a2, a1, a0} = a;
        {b3, b2, b1, b0} = b;
        in_valid = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            apply(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
            step();
            check_count++;
            if (res !== 5'b00000 || out_valid !== 1'b0)
                $display("FAIL reset_%0d: got res=%b valid=%b, want res=00000 valid=0",
                         i, res, out_valid);
            else
                pass_count++;
        end
        rst = 1'b0;
    endtask

    task automatic test_zero();
        apply(4'b0000, 4'b0000, 1'b1);
        step();
        check_count++;
        if (res !== 5'b00000 || out_valid !== 1'b1)
            $display("FAIL zero: got res=%b valid=%b, want res=00000 valid=1", res, out_valid);
        else
            pass_count++;
    endtask

    task automatic test_directed();
        logic [3:0] va [4];
        logic [3:0] vb [4];
        logic [4:0] ve [4];
        va[0] = 4'b0101; vb[0] = 4'b0011; ve[0] = 5'b01000;
        va[1] = 4'b1111; vb[1] = 4'b0001; ve[1] = 5'b10000;
        va[2] = 4'b1111; vb[2] = 4'b1111; ve[2] = 5'b11110;
        va[3] = 4'b1010; vb[3] = 4'b0101; ve[3] = 5'b01111;
        for (int i = 0; i < 4; i++) begin
            apply(va[i], vb[i], 1'b1);
            step();
            check_count++;
            if (res !== ve[i] || out_valid !== 1'b1)
                $display("FAIL directed_%0d: A=%b B=%b got res=%b valid=%b, want res=%b valid=1",
                         i, va[i], vb[i], res, out_valid, ve[i]);
            else
                pass_count++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] exp_sum;
        for (int i = 0; i < 256; i++) begin
            a = 4'(i >> 4);
            b = 4'(i);
            exp_sum = {1'b0, a} + {1'b0, b};
            apply(a, b, 1'b1);
            step();
            check_count++;
            if (res !== exp_sum || out_valid !== 1'b1)
                $display("FAIL sweep: A=%0d B=%0d got res=%0d valid=%b, want res=%0d valid=1",
                         a, b, res, out_valid, exp_sum);
            else
                pass_count++;
        end
    endtask

    task automatic test_gap_reset();
        apply(4'd9, 4'd4, 1'b1);
        step();
        check_count++;
        if (res !== 5'd13 || out_valid !== 1'b1)
            $display("FAIL gap_pre: got res=%0d valid=%b, want res=13 valid=1", res, out_valid);
        else
            pass_count++;

        apply(4'd3, 4'd3, 1'b0);
        step();
        check_count++;
        if (res !== 5'd13 || out_valid !== 1'b0)
            $display("FAIL gap_hold: got res=%0d valid=%b, want res=13 valid=0", res, out_valid);
        else
            pass_count++;

        rst = 1'b1;
        apply(4'd12, 4'd11, 1'b1);
        step();
        check_count++;
        if (res !== 5'd0 || out_valid !== 1'b0)
            $display("FAIL mid_reset: got res=%0d valid=%b, want res=0 valid=0", res, out_valid);
        else
            pass_count++;

        rst = 1'b0;
        apply(4'd7, 4'd8, 1'b1);
        step();
        check_count++;
        if (res !== 5'd15 || out_valid !== 1'b1)
            $display("FAIL resume_0: got res=%0d valid=%b, want res=15 valid=1", res, out_valid);
        else
            pass_count++;

        apply(4'd14, 4'd13, 1'b1);
        step();
        check_count++;
        if (res !== 5'd27 || out_valid !== 1'b1)
            $display("FAIL resume_1: got res=%0d valid=%b, want res=27 valid=1", res, out_valid);
        else
            pass_count++;
    endtask

    initial begin
        pass_count  = 0;
        check_count = 0;
        rst = 1'b1;
        apply(4'd0, 4'd0, 1'b0);
        test_reset();
        test_zero();
        test_directed();
        test_back_to_back();
        test_gap_reset();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
